twd_rot_stage: RTL and testbench

//  Parametrised trivial-twiddle stage between radix-2 butterfly stages of the pipelined FFT.
//  Sum path passes through; diff path is rotated by a per-segment code: x1, -j, -1 or +j.
//  The segment is chosen by a beat counter within the frame.

---
 rtl/twd_pkg.sv | 46 ++++
 rtl/twd_rot_stage_if.sv | 36 +++
 rtl/twd_rot_lane.sv | 53 +++++
 rtl/twd_rot_stage.sv | 92 +++++++++
 tb/tb_twd_rot_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/twd_pkg.sv
// twd_pkg: shared types and helpers for the trivial-twiddle rotation stage.
//   rot_code_e : 2-bit rotation code (x1, -j, -1, +j)
//   sat_neg    : saturating negate of a sign-extended WIDTH-bit value
//   conj_code  : conjugate a rotation code (swap -j and +j)
package twd_pkg;

  // Working width for sat_neg; callers sign-extend into it and truncate back.
  localparam int unsigned NEG_W = 32;

  typedef enum logic [1:0] {
    ROT_P1 = 2'b00,
    ROT_MJ = 2'b01,
    ROT_M1 = 2'b10,
    ROT_PJ = 2'b11
  } rot_code_e;

  typedef struct packed {
    logic                    sat;
    logic signed [NEG_W-1:0] val;
  } neg_res_t;

  // Negate x, interpreted as a width-bit value; the most negative value clamps to max.
  function automatic neg_res_t sat_neg(input logic signed [NEG_W-1:0] x,
                                       input int unsigned             width);
    neg_res_t                r;
    logic signed [NEG_W-1:0] min_v;
    min_v = '1;
    min_v = min_v << (width - 1);
    r.sat = (x == min_v);
    r.val = r.sat ? ~min_v : -x;
    return r;
  endfunction

  // Conjugating the twiddle swaps -j and +j; x1 and -1 are self-conjugate.
  function automatic rot_code_e conj_code(input rot_code_e c);
    rot_code_e r;
    r = c;
    case (c)
      ROT_MJ:  r = ROT_PJ;
      ROT_PJ:  r = ROT_MJ;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/twd_rot_stage_if.sv
// twd_rot_stage_if: beat bus of the twiddle stage.
//   i_* : upstream beat (valid, frame start, inverse mode, sum/diff lanes)
//   o_* : registered output beat (valid, sum/diff lanes, segment, frame last, sat)
//   master : upstream/bench side, slave : twiddle stage side
interface twd_rot_stage_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned LANES = 16,
  parameter int unsigned SEG_W = 2
);
  logic                    i_valid;
  logic                    i_frame_start;
  logic                    i_inv;
  logic signed [WIDTH-1:0] i_sum_re  [LANES];
  logic signed [WIDTH-1:0] i_sum_im  [LANES];
  logic signed [WIDTH-1:0] i_diff_re [LANES];
  logic signed [WIDTH-1:0] i_diff_im [LANES];

  logic                    o_valid;
  logic signed [WIDTH-1:0] o_sum_re  [LANES];
  logic signed [WIDTH-1:0] o_sum_im  [LANES];
  logic signed [WIDTH-1:0] o_diff_re [LANES];
  logic signed [WIDTH-1:0] o_diff_im [LANES];
  logic [SEG_W-1:0]        o_seg_idx;
  logic                    o_frame_last;
  logic                    o_sat;

  modport master (
    output i_valid, i_frame_start, i_inv, i_sum_re, i_sum_im, i_diff_re, i_diff_im,
    input  o_valid, o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_seg_idx, o_frame_last, o_sat
  );

  modport slave (
    input  i_valid, i_frame_start, i_inv, i_sum_re, i_sum_im, i_diff_re, i_diff_im,
    output o_valid, o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_seg_idx, o_frame_last, o_sat
  );
endinterface

// File: rtl/twd_rot_lane.sv
// twd_rot_lane: combinational single-lane complex rotation by x1, -j, -1 or +j.
//   code_i       : rotation code
//   re_i, im_i   : input sample
//   re_o, im_o   : rotated sample (negations saturate)
//   sat_o        : a negation saturated in this lane
module twd_rot_lane
  import twd_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  rot_code_e               code_i,
  input  logic signed [WIDTH-1:0] re_i,
  input  logic signed [WIDTH-1:0] im_i,
  output logic signed [WIDTH-1:0] re_o,
  output logic signed [WIDTH-1:0] im_o,
  output logic                    sat_o
);

  neg_res_t neg_re_c;
  neg_res_t neg_im_c;
  logic     unused_hi_c;

  assign neg_re_c = sat_neg(NEG_W'(re_i), WIDTH);
  assign neg_im_c = sat_neg(NEG_W'(im_i), WIDTH);
  // Upper bits of the negation are pure sign extension after saturation.
  assign unused_hi_c = ^{neg_re_c.val[NEG_W-1:WIDTH], neg_im_c.val[NEG_W-1:WIDTH]};

  // Rotation select.
  always_comb begin
    re_o  = re_i;
    im_o  = im_i;
    sat_o = 1'b0;
    case (code_i)
      ROT_MJ: begin
        re_o  = im_i;
        im_o  = WIDTH'(neg_re_c.val);
        sat_o = neg_re_c.sat;
      end
      ROT_M1: begin
        re_o  = WIDTH'(neg_re_c.val);
        im_o  = WIDTH'(neg_im_c.val);
        sat_o = neg_re_c.sat | neg_im_c.sat;
      end
      ROT_PJ: begin
        re_o  = WIDTH'(neg_im_c.val);
        im_o  = re_i;
        sat_o = neg_im_c.sat;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/twd_rot_stage.sv
// twd_rot_stage: trivial-twiddle stage between radix-2 butterfly stages.
//   clk, rstn : clock, async active-low reset
//   bus       : slave side of twd_rot_stage_if; sum lanes pass through, diff
//               lanes are rotated by the code of the beat's frame segment.
//   Output beat is registered, one cycle after the input beat.
module twd_rot_stage
  import twd_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned LANES     = 16,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned SEG_LEN   = 4,
  parameter logic [2*(FRAME_LEN/SEG_LEN)-1:0] ROT_CODE = 8'b01_00_00_00
) (
  input logic            clk,
  input logic            rstn,
  twd_rot_stage_if.slave bus
);

  localparam int unsigned NSEG    = FRAME_LEN / SEG_LEN;
  localparam int unsigned CNT_W   = $clog2(FRAME_LEN);
  localparam int unsigned SEG_W   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned SEG_SHR = $clog2(SEG_LEN);

  logic [CNT_W-1:0]        cnt_q;
  logic                    inv_q;
  logic [CNT_W-1:0]        eff_cnt_c;
  logic [SEG_W-1:0]        seg_c;
  logic                    inv_c;
  rot_code_e               raw_code_c;
  rot_code_e               code_c;
  logic signed [WIDTH-1:0] rot_re_c [LANES];
  logic signed [WIDTH-1:0] rot_im_c [LANES];
  logic [LANES-1:0]        sat_c;

  // Frame start resyncs the beat to position 0 regardless of the running count.
  assign eff_cnt_c  = (bus.i_valid && bus.i_frame_start) ? '0 : cnt_q;
  assign seg_c      = SEG_W'(eff_cnt_c >> SEG_SHR);
  assign raw_code_c = rot_code_e'(ROT_CODE[2*seg_c +: 2]);
  // Beat 0 uses the freshly presented inverse flag; later beats use the latched one.
  assign inv_c      = (eff_cnt_c == '0) ? bus.i_inv : inv_q;
  assign code_c     = inv_c ? conj_code(raw_code_c) : raw_code_c;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    twd_rot_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .code_i (code_c),
      .re_i   (bus.i_diff_re[l]),
      .im_i   (bus.i_diff_im[l]),
      .re_o   (rot_re_c[l]),
      .im_o   (rot_im_c[l]),
      .sat_o  (sat_c[l])
    );
  end

  // Beat counter, inverse latch and output register; data holds across bubbles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q            <= '0;
      inv_q            <= 1'b0;
      bus.o_valid      <= 1'b0;
      bus.o_seg_idx    <= '0;
      bus.o_frame_last <= 1'b0;
      bus.o_sat        <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        bus.o_sum_re[l]  <= '0;
        bus.o_sum_im[l]  <= '0;
        bus.o_diff_re[l] <= '0;
        bus.o_diff_im[l] <= '0;
      end
    end else begin
      bus.o_valid <= bus.i_valid;
      if (bus.i_valid) begin
        cnt_q <= eff_cnt_c + CNT_W'(1);
        if (eff_cnt_c == '0) begin
          inv_q <= bus.i_inv;
        end
        bus.o_seg_idx    <= seg_c;
        bus.o_frame_last <= (eff_cnt_c == CNT_W'(FRAME_LEN - 1));
        bus.o_sat        <= |sat_c;
        for (int unsigned l = 0; l < LANES; l++) begin
          bus.o_sum_re[l]  <= bus.i_sum_re[l];
          bus.o_sum_im[l]  <= bus.i_sum_im[l];
          bus.o_diff_re[l] <= rot_re_c[l];
          bus.o_diff_im[l] <= rot_im_c[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_twd_rot_stage.sv
// tb_twd_rot_stage: scoreboard bench for twd_rot_stage. Two instances share the
// stimulus: A uses the default rotation codes, B exercises all four codes.
module tb_twd_rot_stage;

  localparam int unsigned W  = 12;
  localparam int unsigned L  = 16;
  localparam int unsigned FL = 16;
  localparam int unsigned SL = 4;
  localparam int unsigned SW = 2;
  localparam logic [7:0] ROT_A = 8'b01_00_00_00;
  localparam logic [7:0] ROT_B = 8'b11_01_00_10;

  typedef logic [L-1:0][W-1:0] vec_t;
  typedef struct packed {
    vec_t          sre;
    vec_t          sim;
    vec_t          dre;
    vec_t          dim;
    logic [SW-1:0] seg;
    logic          last;
    logic          sat;
  } rec_t;
  typedef struct packed {
    rec_t        a;
    rec_t        b;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        q[$];
  rec_t        last_a = '0;
  rec_t        last_b = '0;
  int          mpos = 0;
  bit          minv = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  twd_rot_stage_if #(.WIDTH(W), .LANES(L), .SEG_W(SW)) bus_a ();
  twd_rot_stage_if #(.WIDTH(W), .LANES(L), .SEG_W(SW)) bus_b ();

  twd_rot_stage #(.WIDTH(W), .LANES(L), .FRAME_LEN(FL), .SEG_LEN(SL), .ROT_CODE(ROT_A))
    u_dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  twd_rot_stage #(.WIDTH(W), .LANES(L), .FRAME_LEN(FL), .SEG_LEN(SL), .ROT_CODE(ROT_B))
    u_dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic check_rec(input string tag, input rec_t act, input rec_t exp);
    check({tag, "/sum"},  {act.sre, act.sim}, {exp.sre, exp.sim});
    check({tag, "/diff"}, {act.dre, act.dim}, {exp.dre, exp.dim});
    check({tag, "/seg"},  act.seg,  exp.seg);
    check({tag, "/last"}, act.last, exp.last);
    check({tag, "/sat"},  act.sat,  exp.sat);
  endtask

  function automatic rec_t get_a();
    rec_t r;
    for (int l = 0; l < int'(L); l++) begin
      r.sre[l] = bus_a.o_sum_re[l];
      r.sim[l] = bus_a.o_sum_im[l];
      r.dre[l] = bus_a.o_diff_re[l];
      r.dim[l] = bus_a.o_diff_im[l];
    end
    r.seg  = bus_a.o_seg_idx;
    r.last = bus_a.o_frame_last;
    r.sat  = bus_a.o_sat;
    return r;
  endfunction

  function automatic rec_t get_b();
    rec_t r;
    for (int l = 0; l < int'(L); l++) begin
      r.sre[l] = bus_b.o_sum_re[l];
      r.sim[l] = bus_b.o_sum_im[l];
      r.dre[l] = bus_b.o_diff_re[l];
      r.dim[l] = bus_b.o_diff_im[l];
    end
    r.seg  = bus_b.o_seg_idx;
    r.last = bus_b.o_frame_last;
    r.sat  = bus_b.o_sat;
    return r;
  endfunction

  // Reference: multiply diff by the unit twiddle in plain integers, then clamp.
  function automatic rec_t model(input logic [7:0] rot, input int pos, input bit inv,
                                 input vec_t sre, input vec_t sim, input vec_t dre, input vec_t dim);
    rec_t r;
    int   seg, code, wr, wi, re, im, ore, oim;
    bit   s;
    seg  = pos / int'(SL);
    code = int'((rot >> (2 * seg)) & 8'd3);
    if (inv && (code == 1 || code == 3)) code = 4 - code;
    case (code)
      0:       begin wr = 1;  wi = 0;  end
      1:       begin wr = 0;  wi = -1; end
      2:       begin wr = -1; wi = 0;  end
      default: begin wr = 0;  wi = 1;  end
    endcase
    r.sre = sre;
    r.sim = sim;
    s = 1'b0;
    for (int l = 0; l < int'(L); l++) begin
      re  = int'($signed(dre[l]));
      im  = int'($signed(dim[l]));
      ore = re * wr - im * wi;
      oim = re * wi + im * wr;
      if (ore > 2047)  begin ore = 2047;  s = 1'b1; end
      if (ore < -2048) begin ore = -2048; s = 1'b1; end
      if (oim > 2047)  begin oim = 2047;  s = 1'b1; end
      if (oim < -2048) begin oim = -2048; s = 1'b1; end
      r.dre[l] = W'(ore);
      r.dim[l] = W'(oim);
    end
    r.seg  = SW'(seg);
    r.last = (pos == int'(FL) - 1);
    r.sat  = s;
    return r;
  endfunction

  // One cycle of stimulus; fixed=1 drives every diff lane with (dre, dim).
  task automatic drive(input bit v, input bit fs, input bit inv, input bit fixed,
                       input int dre, input int dim);
    vec_t sre, sim, vre, vim;
    exp_t e;
    @(posedge clk);
    #1;
    for (int l = 0; l < int'(L); l++) begin
      sre[l] = W'($urandom);
      sim[l] = W'($urandom);
      if (fixed) begin
        vre[l] = W'(dre);
        vim[l] = W'(dim);
      end else begin
        vre[l] = ($urandom_range(7) == 0) ? 12'h800 : W'($urandom);
        vim[l] = ($urandom_range(7) == 0) ? 12'h800 : W'($urandom);
      end
      bus_a.i_sum_re[l] = sre[l];  bus_b.i_sum_re[l] = sre[l];
      bus_a.i_sum_im[l] = sim[l];  bus_b.i_sum_im[l] = sim[l];
      bus_a.i_diff_re[l] = vre[l]; bus_b.i_diff_re[l] = vre[l];
      bus_a.i_diff_im[l] = vim[l]; bus_b.i_diff_im[l] = vim[l];
    end
    bus_a.i_valid = v;        bus_b.i_valid = v;
    bus_a.i_frame_start = fs; bus_b.i_frame_start = fs;
    bus_a.i_inv = inv;        bus_b.i_inv = inv;
    if (v) begin
      if (fs) mpos = 0;
      if (mpos == 0) minv = inv;
      e.a   = model(ROT_A, mpos, minv, sre, sim, vre, vim);
      e.b   = model(ROT_B, mpos, minv, sre, sim, vre, vim);
      e.cyc = cyc;
      q.push_back(e);
      mpos = (mpos + 1) % int'(FL);
    end
  endtask

  // Monitor: pop on each output beat, otherwise outputs must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus_a.o_valid || bus_b.o_valid) begin
          if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got a=%0b b=%0b want no beat", bus_a.o_valid, bus_b.o_valid);
          end else begin
            e = q.pop_front();
            check("latency", cyc, e.cyc + 1);
            check("valid_a", bus_a.o_valid, 1'b1);
            check("valid_b", bus_b.o_valid, 1'b1);
            check_rec("beat_a", get_a(), e.a);
            check_rec("beat_b", get_b(), e.b);
            last_a = e.a;
            last_b = e.b;
          end
        end else begin
          check_rec("hold_a", get_a(), last_a);
          check_rec("hold_b", get_b(), last_b);
        end
      end
    end
  end

  initial begin
    bus_a.i_valid = 1'b0; bus_b.i_valid = 1'b0;
    bus_a.i_frame_start = 1'b0; bus_b.i_frame_start = 1'b0;
    bus_a.i_inv = 1'b0; bus_b.i_inv = 1'b0;
    for (int l = 0; l < int'(L); l++) begin
      bus_a.i_sum_re[l] = '0;  bus_b.i_sum_re[l] = '0;
      bus_a.i_sum_im[l] = '0;  bus_b.i_sum_im[l] = '0;
      bus_a.i_diff_re[l] = '0; bus_b.i_diff_re[l] = '0;
      bus_a.i_diff_im[l] = '0; bus_b.i_diff_im[l] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid_a", bus_a.o_valid, 1'b0);
    check_rec("rst_a", get_a(), '0);
    check_rec("rst_b", get_b(), '0);
    @(negedge clk);
    #2 rstn = 1'b1;

    // Default frame, fixed diff
    for (int b = 0; b < int'(FL); b++) drive(1'b1, b == 0, 1'b0, 1'b1, 100, -50);
    // Inverse latched at beat 0, toggled mid-frame; then a normal frame
    for (int b = 0; b < int'(FL); b++) drive(1'b1, b == 0, b < 5, 1'b1, 100, -50);
    for (int b = 0; b < int'(FL); b++) drive(1'b1, b == 0, b >= 5, 1'b1, 100, -50);
    // Saturation corners
    for (int b = 0; b < int'(FL); b++) drive(1'b1, b == 0, 1'b0, 1'b1, -2048, 5);
    for (int b = 0; b < int'(FL); b++) drive(1'b1, b == 0, 1'b0, 1'b1, -2048, -2048);
    // Bubbles every other cycle, with frame start and inv asserted on the bubbles
    for (int b = 0; b < 2 * int'(FL); b++) drive(b % 2 == 0, b == 0 || b % 2 == 1, b % 2 == 1, 1'b0, 0, 0);
    // Resync mid-frame at beat 9
    for (int b = 0; b < 9; b++) drive(1'b1, b == 0, 1'b0, 1'b0, 0, 0);
    for (int b = 0; b < int'(FL); b++) drive(1'b1, b == 0, 1'b1, 1'b0, 0, 0);
    // Reset mid-frame
    for (int b = 0; b < 13; b++) drive(1'b1, b == 0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("drain_before_rst", q.size(), 0);
    @(posedge clk);
    #1 rstn = 1'b0;
    #2;
    check_rec("async_rst_a", get_a(), '0);
    check_rec("async_rst_b", get_b(), '0);
    check("async_rst_valid", bus_a.o_valid, 1'b0);
    mpos = 0;
    minv = 1'b0;
    last_a = '0;
    last_b = '0;
    @(negedge clk);
    #2 rstn = 1'b1;
    for (int b = 0; b < int'(FL); b++) drive(1'b1, 1'b0, 1'b1, 1'b1, 100, -50);
    // Random traffic
    for (int i = 0; i < 300; i++)
      drive($urandom_range(9) < 7, $urandom_range(19) == 0, 1'($urandom_range(1)), 1'b0, 0, 0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("drain_end", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
